// File: rtl/score_pkg.sv
// Shared score-path constants and the converter FSM encoding.
// Score counter and high-score blocks reuse MAX_SCORE from here.
package score_pkg;

  localparam int BIN_W     = 17;
  localparam int DIGITS    = 5;
  localparam int MAX_SCORE = 99999;
  localparam int BCD_W     = 4 * DIGITS;
  localparam int WORK_W    = BCD_W + BIN_W;
  localparam int CNT_W     = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] n,
  output logic [3:0] y
);

  always_comb begin
    y = n;
    if (n >= 4'd5) y = n + 4'd3;
  end

endmodule

// File: rtl/score_bin2bcd.sv
// Iterative binary-to-BCD converter for the score display, one bit per cycle.
// Inputs above MAX_SCORE saturate to 99999 and set overflow.
module score_bin2bcd
  import score_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  localparam logic [BIN_W-1:0] MAX_W = BIN_W'(MAX_SCORE);

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_work;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_corr;
  logic [WORK_W-1:0]  step_word;
  logic [CNT_W-1:0]   cnt;
  logic               clamp_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               accept;
  logic               last_step;

  // Handshake: start is a request qualified by !busy; a request seen in IDLE or
  // DONE is taken on that clock edge, anything seen while busy is dropped.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (state == SHIFT) && (cnt == CNT_W'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .n (bcd_work[4*g +: 4]),
      .y (bcd_corr[4*g +: 4])
    );
  end

  // Correct every digit first, then shift the whole working word; the binary
  // MSB falls into the ones digit.
  assign step_word = {bcd_corr, bin_work} << 1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_step ? DONE : SHIFT;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin_work <= '0;
      bcd_work <= '0;
      cnt      <= '0;
      clamp_q  <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      bin_work <= (bin > MAX_W) ? MAX_W : bin;
      clamp_q  <= (bin > MAX_W);
      bcd_work <= '0;
      cnt      <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      bin_work <= step_word[BIN_W-1:0];
      bcd_work <= step_word[WORK_W-1:BIN_W];
      cnt      <= cnt - CNT_W'(1);
      // Outputs move only here, so the display never sees a partial result.
      if (last_step) begin
        bcd_q <= step_word[WORK_W-1:BIN_W];
        ovf_q <= clamp_q;
      end
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bin2bcd.sv
// Directed bench for score_bin2bcd: vector table plus hand-written sequences
// for ignored start, mid-conversion reset and back-to-back restarts.
module tb_score_bin2bcd;
  import score_pkg::*;

  logic             clock;
  logic             resetn;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd;
  logic             overflow;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] exp_bcd;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[12];

  score_bin2bcd dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one request at a negedge, release start, then count cycles (edges
  // after the accepting edge) until done is seen. Bounded at 40 cycles.
  task automatic convert(input logic [BIN_W-1:0] v, output logic [BCD_W-1:0] got_bcd,
                         output logic got_ovf, output int lat, output int busy_cnt);
    @(negedge clock);
    start = 1'b1;
    bin   = v;
    @(negedge clock);
    start = 1'b0;
    bin   = $urandom_range(0, 131071);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    got_bcd = bcd;
    got_ovf = overflow;
  endtask

  initial begin
    logic [BCD_W-1:0] got_bcd;
    logic             got_ovf;
    int               lat;
    int               bcnt;
    int               pulses;
    int               first_done;
    int               second_done;
    logic [BCD_W-1:0] first_bcd;
    logic [BCD_W-1:0] second_bcd;

    vecs[0]  = '{17'd0,      20'h00000, 1'b0};
    vecs[1]  = '{17'd12345,  20'h12345, 1'b0};
    vecs[2]  = '{17'd99999,  20'h99999, 1'b0};
    vecs[3]  = '{17'd100000, 20'h99999, 1'b1};
    vecs[4]  = '{17'd131071, 20'h99999, 1'b1};
    vecs[5]  = '{17'd7,      20'h00007, 1'b0};
    vecs[6]  = '{17'd10,     20'h00010, 1'b0};
    vecs[7]  = '{17'd65535,  20'h65535, 1'b0};
    vecs[8]  = '{17'd80000,  20'h80000, 1'b0};
    vecs[9]  = '{17'd99998,  20'h99998, 1'b0};
    vecs[10] = '{17'd59,     20'h00059, 1'b0};
    vecs[11] = '{17'd90909,  20'h90909, 1'b0};

    resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    resetn = 1'b1;
    @(negedge clock);

    // table-driven conversions
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].bin, got_bcd, got_ovf, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd17);
      check($sformatf("vec%0d_bcd", i), 32'(got_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_ovf", i), 32'(got_ovf), 32'(vecs[i].exp_ovf));
      @(negedge clock);
      check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_bcd_held", i), 32'(bcd), 32'(vecs[i].exp_bcd));
    end

    // start while busy is ignored
    @(negedge clock);
    start = 1'b1;
    bin   = 17'd500;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    first_done = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin   = 17'd42;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = k;
        first_bcd = bcd;
      end
      @(negedge clock);
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_done_cycle", 32'(first_done), 32'd17);
    check("ignore_bcd", 32'(first_bcd), 32'h00500);

    // reset in the middle of a conversion
    @(negedge clock);
    start = 1'b1;
    bin   = 17'd4321;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    convert(17'd4321, got_bcd, got_ovf, lat, bcnt);
    check("midrst_restart_latency", 32'(lat), 32'd17);
    check("midrst_restart_bcd", 32'(got_bcd), 32'h04321);

    // back-to-back with start held high
    @(negedge clock);
    start = 1'b1;
    bin   = 17'd1;
    @(negedge clock);
    bin = 17'd99;
    first_done  = -1;
    second_done = -1;
    first_bcd   = '0;
    second_bcd  = '0;
    for (int k = 0; k < 60 && second_done < 0; k++) begin
      if (done) begin
        if (first_done < 0) begin
          first_done = k;
          first_bcd  = bcd;
        end else begin
          second_done = k;
          second_bcd  = bcd;
          start = 1'b0;
        end
      end
      if (second_done < 0) @(negedge clock);
    end
    start = 1'b0;
    check("b2b_first_cycle", 32'(first_done), 32'd17);
    check("b2b_spacing", 32'(second_done - first_done), 32'd18);
    check("b2b_first_bcd", 32'(first_bcd), 32'h00001);
    check("b2b_second_bcd", 32'(second_bcd), 32'h00099);
    @(negedge clock);
    check("b2b_idle_after", 32'(dbg_state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
